// File: rtl/lvds_hiss_lanes.sv
// lvds_hiss_lanes: multi-lane HISS LVDS pad model with bias power-up FSM, drivers, forwarded clock and deglitched receivers.
// Optional HISS_LOOPBACK_EN adds hiss_lpbk, which routes each driver pair back into its receiver.
module lvds_hiss_lanes #(
  parameter int NUM_LANES       = 2,
  parameter int BIAS_SETTLE_CYC = 16,
  parameter int FILT_LEN        = 3
) (
  input  logic                 hiss_clk,
  input  logic                 hiss_rst,
  input  logic                 hiss_biasen,
  input  logic                 hiss_replien,
  output logic                 hiss_ready,
  input  logic [NUM_LANES-1:0] hiss_rxd,
  input  logic [NUM_LANES-1:0] hiss_rxen,
  output logic [NUM_LANES-1:0] hissrxp,
  output logic [NUM_LANES-1:0] hissrxn,
  input  logic                 hiss_clken,
  output logic                 hissclkp,
  output logic                 hissclkn,
  input  logic [NUM_LANES-1:0] hisstxp,
  input  logic [NUM_LANES-1:0] hisstxn,
  input  logic [NUM_LANES-1:0] hiss_txen,
  output logic [NUM_LANES-1:0] hiss_txd,
  output logic [NUM_LANES-1:0] hiss_txerr,
`ifdef HISS_LOOPBACK_EN
  input  logic                 hiss_lpbk,
`endif
  input  logic                 hiss_errclr
);
  localparam int CW = BIAS_SETTLE_CYC > 1 ? $clog2(BIAS_SETTLE_CYC) : 1;
  localparam int FW = FILT_LEN > 1 ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIAS_SETTLE_CYC - 1);
  localparam logic [FW-1:0] FLAST = FW'(FILT_LEN - 1);
  typedef enum logic [1:0] {OFF, SETTLE, READY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bias_on;
  logic [NUM_LANES-1:0] rxp_q, rxn_q, src_p, src_n;
  logic ph_q, clkp_q, clkn_q, clk_en;
  assign bias_on = hiss_biasen & hiss_replien;
  always_comb begin
    state_d = !bias_on ? OFF :
              state_q == OFF ? SETTLE :
              (state_q == SETTLE && cnt_q == LAST) ? READY : state_q;
    cnt_d = (bias_on && state_q == SETTLE && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
  end
  assign hiss_ready = state_q == READY;
  assign clk_en = hiss_ready & hiss_clken;
  always_ff @(posedge hiss_clk) begin
    if (hiss_rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      rxp_q   <= '0;
      rxn_q   <= '0;
      ph_q    <= 1'b0;
      clkp_q  <= 1'b0;
      clkn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rxp_q   <= {NUM_LANES{hiss_ready}} & hiss_rxen & hiss_rxd;
      rxn_q   <= {NUM_LANES{hiss_ready}} & hiss_rxen & ~hiss_rxd;
      ph_q    <= clk_en & ~ph_q;
      clkp_q  <= clk_en & ~ph_q;
      clkn_q  <= clk_en & ph_q;
    end
  end
  assign hissrxp  = rxp_q;
  assign hissrxn  = rxn_q;
  assign hissclkp = clkp_q;
  assign hissclkn = clkn_q;
`ifdef HISS_LOOPBACK_EN
  assign src_p = hiss_lpbk ? rxp_q : hisstxp;
  assign src_n = hiss_lpbk ? rxn_q : hisstxn;
`else
  assign src_p = hisstxp;
  assign src_n = hisstxn;
`endif
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_rx
    logic [1:0] s1_q, s2_q;
    logic [FW-1:0] fc_q, fc_d;
    logic f_q, f_d, e_q, e_d, act, valid, diff;
    assign act   = hiss_ready & hiss_txen[i];
    assign valid = s2_q[1] ^ s2_q[0];
    assign diff  = valid & (s2_q[1] != f_q);
    always_comb begin
      f_d  = act & (diff && fc_q == FLAST ? ~f_q : f_q);
      fc_d = (act && diff && fc_q != FLAST) ? fc_q + 1'b1 : '0;
      e_d  = (act & ~valid) | (e_q & ~hiss_errclr);
    end
    always_ff @(posedge hiss_clk) begin
      if (hiss_rst) begin
        s1_q <= '0;
        s2_q <= '0;
        fc_q <= '0;
        f_q  <= 1'b0;
        e_q  <= 1'b0;
      end else begin
        s1_q <= {src_p[i], src_n[i]};
        s2_q <= s1_q;
        fc_q <= fc_d;
        f_q  <= f_d;
        e_q  <= e_d;
      end
    end
    assign hiss_txd[i]   = f_q;
    assign hiss_txerr[i] = e_q;
  end
endmodule

// File: tb/tb_lvds_hiss_lanes.sv
// tb_lvds_hiss_lanes: directed bench for lvds_hiss_lanes with default parameters.
module tb_lvds_hiss_lanes;
  logic clk = 1'b0, rst = 1'b1;
  logic biasen = 1'b0, replien = 1'b0, clken = 1'b0, errclr = 1'b0;
  logic [1:0] rxd = '0, rxen = '0, txp = 2'b00, txn = 2'b01, txen = '0;
  logic ready, clkp, clkn;
  logic [1:0] rxp, rxn, txd, txerr;
  int checks = 0, errors = 0;

  lvds_hiss_lanes dut (
    .hiss_clk(clk), .hiss_rst(rst), .hiss_biasen(biasen), .hiss_replien(replien),
    .hiss_ready(ready), .hiss_rxd(rxd), .hiss_rxen(rxen), .hissrxp(rxp), .hissrxn(rxn),
    .hiss_clken(clken), .hissclkp(clkp), .hissclkn(clkn), .hisstxp(txp), .hisstxn(txn),
    .hiss_txen(txen), .hiss_txd(txd), .hiss_txerr(txerr), .hiss_errclr(errclr)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    step(2);
    check("rst_ready", 32'(ready), 0);
    check("rst_rxp", 32'(rxp), 0);
    check("rst_clk", 32'({clkp, clkn}), 0);
    check("rst_txd", 32'(txd), 0);
    check("rst_txerr", 32'(txerr), 0);
    rst = 1'b0; biasen = 1'b1; replien = 1'b1;
    step(16);
    check("pwr_16", 32'(ready), 0);
    step(1);
    check("pwr_17", 32'(ready), 1);
    rst = 1'b1;
    step(1);
    check("rst_mid_ready", 32'(ready), 0);
    rst = 1'b0;
    step(10);
    replien = 1'b0;
    step(1);
    check("drop_ready", 32'(ready), 0);
    replien = 1'b1;
    step(16);
    check("restart_16", 32'(ready), 0);
    step(1);
    check("restart_17", 32'(ready), 1);
    rxen = 2'b01; rxd = 2'b11;
    step(1);
    check("drv_p", 32'(rxp), 32'b01);
    check("drv_n", 32'(rxn), 32'b00);
    rxen = 2'b11; rxd = 2'b10;
    step(1);
    check("drv2_p", 32'(rxp), 32'b10);
    check("drv2_n", 32'(rxn), 32'b01);
    rxen = 2'b00;
    step(1);
    check("drv_off", 32'({rxp, rxn}), 0);
    clken = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      check("fwd_clk", 32'({clkp, clkn}), (k % 2 == 0) ? 32'b10 : 32'b01);
    end
    clken = 1'b0;
    step(1);
    check("fwd_off", 32'({clkp, clkn}), 0);
    txen = 2'b01;
    step(3);
    check("rx_idle", 32'({txd, txerr}), 0);
    txp = 2'b01; txn = 2'b00;
    step(4);
    check("rx_rise_4", 32'(txd), 0);
    step(1);
    check("rx_rise_5", 32'(txd), 32'b01);
    txp = 2'b00; txn = 2'b01;
    step(4);
    check("rx_fall_4", 32'(txd), 32'b01);
    step(1);
    check("rx_fall_5", 32'(txd), 0);
    txp = 2'b01; txn = 2'b00;
    step(5);
    check("rx_rise2", 32'(txd), 32'b01);
    txp = 2'b00; txn = 2'b01;
    step(2);
    txp = 2'b01; txn = 2'b00;
    for (int k = 0; k < 8; k++) begin
      step(1);
      check("glitch_txd", 32'(txd), 32'b01);
    end
    check("glitch_err", 32'(txerr), 0);
    txn = 2'b01;
    step(1);
    txn = 2'b00;
    step(1);
    check("err_2", 32'(txerr), 0);
    step(1);
    check("err_3", 32'(txerr), 32'b01);
    check("err_hold_txd", 32'(txd), 32'b01);
    step(3);
    check("err_sticky", 32'(txerr), 32'b01);
    errclr = 1'b1;
    step(1);
    check("errclr", 32'(txerr), 0);
    errclr = 1'b0;
    txn = 2'b01;
    step(1);
    txn = 2'b00;
    step(1);
    errclr = 1'b1;
    step(1);
    check("set_wins", 32'(txerr), 32'b01);
    step(1);
    check("clr_alone", 32'(txerr), 0);
    errclr = 1'b0;
    rxen = 2'b11; rxd = 2'b01; clken = 1'b1;
    step(2);
    check("pre_rst_rxp", 32'(rxp), 32'b01);
    rst = 1'b1;
    step(1);
    check("rst_end_ready", 32'(ready), 0);
    check("rst_end_pads", 32'({rxp, rxn, clkp, clkn}), 0);
    check("rst_end_rx", 32'({txd, txerr}), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
